// File: rtl/riscv_multicycle_fsm.sv
// rtl/riscv_multicycle_fsm.sv - main control FSM for the multicycle RISC-V core
//
// Purpose:
//   Steps each instruction through fetch / decode / execute / memory /
//   writeback. It drives the datapath mux selects and enables, and it gives
//   the 2-bit ALU op to the ALU-control decoder. Cache accesses stall on
//   i_mem_ready. It also counts retired instructions.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_op[6:0]        opcode from the instruction register
//   i_zero           ALU zero flag (used only in BEQ)
//   i_mem_ready      cache acknowledge for the current request
//   o_mem_req        cache access request
//   o_mem_write      request is a store
//   o_adr_src        address select: 0 = PC, 1 = ALUOut
//   o_ir_write       load instruction register
//   o_pc_write       load PC
//   o_reg_write      register-file write enable
//   o_result_src     00 = ALUOut, 01 = read data, 10 = ALU result
//   o_alu_src_a      00 = PC, 01 = OldPC, 10 = rs1
//   o_alu_src_b      00 = rs2, 01 = immediate, 10 = constant 4
//   o_imm_src        immediate format select
//   o_alu_op         00 = add, 01 = subtract/compare, 10 = funct decode
//   o_illegal_op     high while trapped on an unknown opcode
//   o_retire_count   retired-instruction counter

module riscv_multicycle_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_op,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_write,
  output logic             o_adr_src,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic             o_reg_write,
  output logic [1:0]       o_result_src,
  output logic [1:0]       o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_imm_src,
  output logic [1:0]       o_alu_op,
  output logic             o_illegal_op,
  output logic [CNT_W-1:0] o_retire_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retire_count;

  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_imm_src;
  logic [1:0] w_alu_op;
  logic       w_illegal_op;
  logic       w_retire;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Every state that can reach FETCH (other than FETCH stalling on itself)
  // is the last cycle of a completed instruction. TRAP never reaches FETCH,
  // so the counter holds there.
  assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_retire_count <= '0;
    end else if (w_retire) begin
      r_retire_count <= r_retire_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_illegal_op = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC + 4 is computed in the same cycle. The IR and PC load only on
        // the cycle the cache acknowledges the request.
        w_mem_req    = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = i_mem_ready;
        w_pc_write   = i_mem_ready;
        if (i_mem_ready) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // The branch target OldPC + imm is computed here and waits in ALUOut.
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (i_op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_JAL:            w_next = S_JAL;
          OP_BRANCH:         w_next = S_BEQ;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        // op[5] tells a store (0100011) from a load (0000011).
        w_next      = i_op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (i_mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        if (i_mem_ready) begin
          w_next = S_FETCH;
        end
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b00;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        // The target comes from ALUOut (computed in DECODE). OldPC + 4 is
        // computed now and written as the link in ALUWB.
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
        w_next      = S_ALUWB;
      end
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b00;
        w_alu_op    = 2'b01;
        w_pc_write  = i_zero;
        w_next      = S_FETCH;
      end
      S_TRAP: begin
        w_illegal_op = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  always_comb begin
    w_imm_src = 2'b00;
    case (i_op)
      OP_STORE:  w_imm_src = 2'b01;
      OP_BRANCH: w_imm_src = 2'b10;
      OP_JAL:    w_imm_src = 2'b11;
      default:   w_imm_src = 2'b00;
    endcase
  end

  // The state resets to FETCH, and FETCH itself requests memory. So the
  // decoded outputs are masked while reset is held. This keeps the cache
  // idle until the first cycle after deassertion.
  assign o_mem_req      = i_rst ? 1'b0  : w_mem_req;
  assign o_mem_write    = i_rst ? 1'b0  : w_mem_write;
  assign o_adr_src      = i_rst ? 1'b0  : w_adr_src;
  assign o_ir_write     = i_rst ? 1'b0  : w_ir_write;
  assign o_pc_write     = i_rst ? 1'b0  : w_pc_write;
  assign o_reg_write    = i_rst ? 1'b0  : w_reg_write;
  assign o_result_src   = i_rst ? 2'b00 : w_result_src;
  assign o_alu_src_a    = i_rst ? 2'b00 : w_alu_src_a;
  assign o_alu_src_b    = i_rst ? 2'b00 : w_alu_src_b;
  assign o_imm_src      = i_rst ? 2'b00 : w_imm_src;
  assign o_alu_op       = i_rst ? 2'b00 : w_alu_op;
  assign o_illegal_op   = i_rst ? 1'b0  : w_illegal_op;
  assign o_retire_count = r_retire_count;

endmodule

// File: doc/riscv_multicycle_fsm.md
# riscv_multicycle_fsm

Main control state machine for the multicycle RISC-V core, sitting directly upstream of the ALU-control decoder. It sequences every instruction through fetch/decode/execute/memory/writeback, drives the datapath mux selects and enables, and produces the 2-bit `alu_op` consumed by the ALU-control stage. Memory accesses go through the cache and stall on its ready handshake. It also counts retired instructions.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  7  opcode from the instruction register; valid from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  cache acknowledges the current request this cycle.
- `mem_req`  out  1  cache access request.
- `mem_write`  out  1  request is a store; only asserted together with `mem_req`.
- `adr_src`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load instruction register.
- `pc_write`  out  1  load PC.
- `reg_write`  out  1  register-file write enable.
- `result_src`  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b`  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- `imm_src`  out  2  immediate format select.
- `alu_op`  out  2  to ALU control: 00 = add, 01 = subtract/compare, 10 = decode funct fields.
- `illegal_op`  out  1  high while in TRAP.
- `retire_count`  out  CNT_W  retired-instruction count.

## Operation
- States, 4-bit: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ, TRAP.
- Every output defaults to 0 unless listed for a state.
- FETCH
  - Outputs: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `result_src`=10, `alu_op`=00; `ir_write`=`pc_write`=`mem_ready`.
  - Transition: to DECODE on `mem_ready`, else stay.
- DECODE
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (branch target).
  - Transitions on `op`:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other value -> TRAP
- MEMADR
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00.
  - Transition: to MEMREAD if `op[5]`=0, else to MEMWRITE.
- MEMREAD
  - Outputs: `mem_req`=1, `adr_src`=1.
  - Transition: to MEMWB on `mem_ready`, else stay.
- MEMWB
  - Outputs: `result_src`=01, `reg_write`=1.
  - Transition: to FETCH.
- MEMWRITE
  - Outputs: `mem_req`=1, `mem_write`=1, `adr_src`=1.
  - Transition: to FETCH on `mem_ready`, else stay.
- EXECR
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10.
  - Transition: to ALUWB.
- EXECI
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10.
  - Transition: to ALUWB.
- ALUWB
  - Outputs: `result_src`=00, `reg_write`=1.
  - Transition: to FETCH.
- JAL
  - Outputs: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1.
  - Transition: to ALUWB (link write).
- BEQ
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `pc_write`=`zero`.
  - Transition: to FETCH.
- TRAP
  - Outputs: `illegal_op`=1.
  - Transition: none; stays until `rst`.
- `imm_src` is combinational from `op` in every state:
  - 0000011 or 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - any other value -> 00
- `retire_count` increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Wraps from 2^CNT_W-1 to 0.
  - Holds in TRAP.
- `mem_ready` is ignored outside FETCH, MEMREAD and MEMWRITE.

## Timing
- Reset:
  - `rst` high asynchronously forces state to FETCH and `retire_count` to 0.
  - While `rst` is high, all outputs are 0, including `mem_req`.
  - First `mem_req` is on the first cycle after deassertion.
- Reset mid-instruction aborts the instruction immediately; no partial write is counted.
- State registers update on the rising edge of `clk`. Outputs are combinational from state, plus `mem_ready`/`zero` where listed.
- Cycles per instruction with zero-wait cache (`mem_ready` high on the first request cycle):
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - jal 4
  - beq 3
- Each cycle with `mem_ready` low during a request adds exactly one cycle. All outputs hold steady while stalled.
- `ir_write` and `pc_write` in FETCH pulse for exactly the one cycle where `mem_ready` is 1.

## Test plan
- Reset, then lw (`op`=0000011) with `mem_ready`=1 every request:
  - States FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH.
  - `reg_write`=1 with `result_src`=01 in cycle 5.
  - `retire_count` becomes 1.
- sw with `mem_ready` low for 3 cycles in MEMWRITE:
  - `mem_req`=`mem_write`=1 held for 4 cycles, `adr_src`=1.
  - Returns to FETCH; total 7 cycles.
- R-type then I-type:
  - `alu_op`=10 in EXECR and EXECI.
  - `alu_src_b`=00 then 01.
  - `imm_src`=00.
  - `retire_count` increments by 2.
- beq:
  - With `zero`=1: `pc_write`=1 in BEQ with `alu_op`=01.
  - With `zero`=0: `pc_write`=0 in BEQ.
  - 3 cycles each.
- jal:
  - `pc_write`=1 in JAL.
  - `reg_write`=1 in the next cycle (ALUWB).
  - `imm_src`=11.
- `op`=1111111 in DECODE:
  - TRAP with `illegal_op`=1 held and `retire_count` frozen.
  - Asserting `rst` mid-stall in MEMREAD returns to FETCH with all outputs 0.
- Counter preload to 2^CNT_W-1, then retire one instruction: `retire_count` wraps to 0.
